sdma_chan_arbiter: RTL

- Shares one SDMA channel of the cell macro between N_REQ fabric requesters, for example the decimation-filter FIFO and the raw I2S capture FIFO.
- Round-robin arbitration; sequences the Req/Sreq -> Active -> Done handshake with the macro.
- Returns a per-requester done pulse, and a per-requester error pulse on handshake timeout.
- Sits between the FPGA IP requesters and the macro SDMA_Req/Sreq/Done/Active bit for the channel.

---
 rtl/sdma_chan_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sdma_chan_arbiter.sv
// Round-robin arbiter sharing one SDMA channel of the cell macro between
// N_REQ fabric requesters; sequences Req/Sreq -> Active -> Done with timeout.
module sdma_chan_arbiter #(
    parameter int              N_REQ   = 2,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd1000
) (
    input  logic             WB_CLK,
    input  logic             WB_RST_n,
    input  logic             enable_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] sreq_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [N_REQ-1:0] done_o,
    output logic [N_REQ-1:0] err_o,
    output logic             err_sts_o,
    input  logic             err_clr_i,
    output logic             busy_o,
    output logic             SDMA_Req_o,
    output logic             SDMA_Sreq_o,
    input  logic             SDMA_Active_i,
    input  logic             SDMA_Done_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACT = 2'd1,
        ST_XFER     = 2'd2
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(N_REQ - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // First set request at or after ptr, wrapping modulo N_REQ.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] sel;
        logic             found;
        idx   = ptr;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
            idx = ptr_inc(idx);
        end
        return sel;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [TO_W-1:0]  cnt_r, cnt_nxt_s;
    logic [PTR_W-1:0] rr_ptr_r, rr_nxt_s;
    logic [PTR_W-1:0] gidx_r, gidx_nxt_s;
    logic [PTR_W-1:0] pick_s;
    logic [N_REQ-1:0] grant_r, grant_nxt_s;
    logic [N_REQ-1:0] done_r, done_nxt_s;
    logic [N_REQ-1:0] err_r, err_nxt_s;
    logic             err_sts_r, err_sts_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             req_r, req_nxt_s;
    logic             sreq_r, sreq_nxt_s;
    logic             fin_ok_s, fin_err_s;

    // Next-state and next-output computation for the handshake sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rr_nxt_s    = rr_ptr_r;
        gidx_nxt_s  = gidx_r;
        grant_nxt_s = grant_r;
        req_nxt_s   = req_r;
        sreq_nxt_s  = sreq_r;
        done_nxt_s  = {N_REQ{1'b0}};
        err_nxt_s   = {N_REQ{1'b0}};
        busy_nxt_s  = busy_r;
        fin_ok_s    = 1'b0;
        fin_err_s   = 1'b0;
        pick_s      = rr_pick(req_i, rr_ptr_r);

        case (state_r)
            ST_IDLE: begin
                if (enable_i && (|req_i)) begin
                    gidx_nxt_s  = pick_s;
                    grant_nxt_s = onehot(pick_s);
                    req_nxt_s   = 1'b1;
                    sreq_nxt_s  = sreq_i[pick_s];
                    cnt_nxt_s   = {TO_W{1'b0}};
                    state_nxt_s = ST_WAIT_ACT;
                end else begin
                    grant_nxt_s = {N_REQ{1'b0}};
                    req_nxt_s   = 1'b0;
                    sreq_nxt_s  = 1'b0;
                end
            end
            ST_WAIT_ACT: begin
                if (SDMA_Active_i && SDMA_Done_i) begin
                    fin_ok_s = 1'b1;
                end else if (SDMA_Active_i) begin
                    req_nxt_s   = 1'b0;
                    sreq_nxt_s  = 1'b0;
                    cnt_nxt_s   = {TO_W{1'b0}};
                    state_nxt_s = ST_XFER;
                end else if (cnt_r == TIMEOUT - TO_W'(1)) begin
                    fin_err_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + TO_W'(1);
                end
            end
            ST_XFER: begin
                if (SDMA_Done_i) begin
                    fin_ok_s = 1'b1;
                end else if (cnt_r == TIMEOUT - TO_W'(1)) begin
                    fin_err_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + TO_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = {N_REQ{1'b0}};
                req_nxt_s   = 1'b0;
                sreq_nxt_s  = 1'b0;
                cnt_nxt_s   = {TO_W{1'b0}};
            end
        endcase

        // Completion and abort share the release path; only the pulse differs.
        if (fin_ok_s || fin_err_s) begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = {N_REQ{1'b0}};
            req_nxt_s   = 1'b0;
            sreq_nxt_s  = 1'b0;
            cnt_nxt_s   = {TO_W{1'b0}};
            rr_nxt_s    = ptr_inc(gidx_r);
            done_nxt_s  = fin_ok_s ? onehot(gidx_r) : {N_REQ{1'b0}};
            err_nxt_s   = fin_err_s ? onehot(gidx_r) : {N_REQ{1'b0}};
            busy_nxt_s  = 1'b0;
        end else begin
            busy_nxt_s = (state_nxt_s != ST_IDLE);
        end

        if (fin_err_s) begin
            err_sts_nxt_s = 1'b1;
        end else if (err_clr_i) begin
            err_sts_nxt_s = 1'b0;
        end else begin
            err_sts_nxt_s = err_sts_r;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {TO_W{1'b0}};
            rr_ptr_r  <= {PTR_W{1'b0}};
            gidx_r    <= {PTR_W{1'b0}};
            grant_r   <= {N_REQ{1'b0}};
            done_r    <= {N_REQ{1'b0}};
            err_r     <= {N_REQ{1'b0}};
            err_sts_r <= 1'b0;
            busy_r    <= 1'b0;
            req_r     <= 1'b0;
            sreq_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            rr_ptr_r  <= rr_nxt_s;
            gidx_r    <= gidx_nxt_s;
            grant_r   <= grant_nxt_s;
            done_r    <= done_nxt_s;
            err_r     <= err_nxt_s;
            err_sts_r <= err_sts_nxt_s;
            busy_r    <= busy_nxt_s;
            req_r     <= req_nxt_s;
            sreq_r    <= sreq_nxt_s;
        end
    end

    assign grant_o     = grant_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign err_sts_o   = err_sts_r;
    assign busy_o      = busy_r;
    assign SDMA_Req_o  = req_r;
    assign SDMA_Sreq_o = sreq_r;

endmodule
